// File: rtl/bram_dump_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_dump_streamer_pkg
// Purpose  : Shared state encodings, limits and helpers for the BRAM dump
//            streamer and its word serializer.
// Revision : 1.0 - initial release
// ============================================================================
package bram_dump_streamer_pkg;

   // Dump controller states (3-bit encoding)
   typedef enum logic [2:0] {
      DUMP_ST_IDLE    = 3'd0,
      DUMP_ST_ISSUE   = 3'd1,
      DUMP_ST_WAIT    = 3'd2,
      DUMP_ST_CAPTURE = 3'd3,
      DUMP_ST_SEND    = 3'd4,
      DUMP_ST_DONE    = 3'd5
   } dump_state_e;

   // Largest number of words a single dump may request; larger counts clamp.
   localparam int MAX_WORDS = 256;

   // ceil(log2(n)) but never below one bit, so counters always have a width.
   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_dump_streamer_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bram_dump_streamer_word_serializer
// Purpose  : Holds one captured memory word and presents it byte by byte on a
//            valid/ready interface, holding each byte until it is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module bram_dump_streamer_word_serializer
   import bram_dump_streamer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  flush,
   input  logic                  tx_ready,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   output logic                  word_done
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int IDX_W  = clog2_min1(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic                  handshake;
   logic [IDX_W-1:0]      byte_sel;

   // Byte order: byte_idx counts transfers, byte_sel picks the lane.
   generate
      if (BIG_ENDIAN) begin : g_big_endian
         assign byte_sel = LAST_IDX - idx_q;
      end else begin : g_little_endian
         assign byte_sel = idx_q;
      end
   endgenerate

   assign handshake = valid_q && tx_ready;
   assign word_done = handshake && (idx_q == LAST_IDX);
   assign tx_valid  = valid_q;
   assign tx_data   = word_q[{byte_sel, 3'b000} +: 8];

   // Next-state: flush beats load beats handshake; valid only falls on the
   // last handshake of a word or on flush, so a stalled byte never changes.
   always_comb begin
      word_d  = word_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         word_d  = load_data;
         idx_d   = '0;
         valid_d = 1'b1;
      end else if (handshake) begin
         if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Word, byte index and valid registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/bram_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : bram_dump_streamer
// Purpose  : Walks a window of a bram32 through its debug read port and
//            streams every word out as bytes over a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
module bram_dump_streamer
   import bram_dump_streamer_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1,
   parameter bit BIG_ENDIAN   = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH-2:0] word_count,
   input  logic                  abort,
   output logic [ADDR_WIDTH-1:0] debug_addr,
   input  logic [DATA_WIDTH-1:0] debug_data,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int CNT_W  = ADDR_WIDTH - 1;
   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int LAT_W  = clog2_min1(READ_LATENCY + 1);
   localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(NBYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(NBYTES - 1);

   dump_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]      rem_q, rem_d;
   logic [LAT_W-1:0]      lat_q, lat_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ser_load;
   logic                  word_done;

   assign debug_addr = addr_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign ser_load   = (state_q == DUMP_ST_CAPTURE);

   // Controller next-state: rem_q counts words still to send including the
   // current one; a zero count passes through ISSUE so busy shows one cycle.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      lat_d   = lat_q;
      case (state_q)
         DUMP_ST_IDLE: begin
            if (start) begin
               addr_d  = base_addr & ALIGN_MASK;
               rem_d   = (32'(word_count) > MAX_WORDS) ? CNT_W'(MAX_WORDS) : word_count;
               state_d = DUMP_ST_ISSUE;
            end
         end
         DUMP_ST_ISSUE: begin
            if (rem_q == '0) begin
               state_d = DUMP_ST_DONE;
            end else if (READ_LATENCY == 0) begin
               state_d = DUMP_ST_CAPTURE;
            end else begin
               lat_d   = LAT_W'(READ_LATENCY);
               state_d = DUMP_ST_WAIT;
            end
         end
         DUMP_ST_WAIT: begin
            lat_d = lat_q - 1'b1;
            if (lat_d == '0) begin
               state_d = DUMP_ST_CAPTURE;
            end
         end
         DUMP_ST_CAPTURE: begin
            state_d = DUMP_ST_SEND;
         end
         DUMP_ST_SEND: begin
            if (word_done) begin
               if (rem_q > CNT_W'(1)) begin
                  addr_d  = addr_q + WORD_STEP;
                  rem_d   = rem_q - 1'b1;
                  state_d = DUMP_ST_ISSUE;
               end else begin
                  state_d = DUMP_ST_DONE;
               end
            end
         end
         DUMP_ST_DONE: begin
            state_d = DUMP_ST_IDLE;
         end
         default: begin
            state_d = DUMP_ST_IDLE;
         end
      endcase
      if (abort && (state_q != DUMP_ST_IDLE)) begin
         state_d = DUMP_ST_IDLE;
      end
      busy_d = (state_d != DUMP_ST_IDLE) && (state_d != DUMP_ST_DONE);
      done_d = (state_d == DUMP_ST_DONE);
   end

   // Controller registers with registered busy/done outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= DUMP_ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         lat_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         lat_q   <= lat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   bram_dump_streamer_word_serializer #(
      .DATA_WIDTH (DATA_WIDTH),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_serializer (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load),
      .load_data (debug_data),
      .flush     (abort),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .word_done (word_done)
   );

endmodule
`default_nettype wire

// File: tb/tb_bram_dump_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_dump_streamer
// Purpose  : Directed self-checking bench; a little-endian and a big-endian
//            instance share stimulus and a registered-read memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_dump_streamer;

   logic        clk = 1'b0;
   logic        rst, start, abort, tx_ready;
   logic [9:0]  base_addr;
   logic [8:0]  word_count;
   logic [9:0]  le_addr, be_addr;
   logic [31:0] le_rd, be_rd;
   logic [7:0]  le_data, be_data;
   logic        le_valid, be_valid, le_busy, be_busy, le_done, be_done;

   logic [31:0] mem [0:255];

   int total = 0;
   int bad   = 0;

   logic [7:0] le_q[$];
   logic [7:0] be_q[$];
   int         le_done_cnt, be_done_cnt, valid_seen, hold_err;
   bit         stall_pend;
   logic [7:0] stall_data;

   bit         rdy_mode = 1'b0;
   int         rdy_ph   = 0;
   logic [3:0] rdy_pat  = 4'b1001;

   always #5 clk = ~clk;

   // bram32 debug port model, one-cycle registered read
   always @(posedge clk) begin
      le_rd <= mem[le_addr[9:2]];
      be_rd <= mem[be_addr[9:2]];
   end

   bram_dump_streamer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1), .BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .abort(abort), .debug_addr(le_addr), .debug_data(le_rd), .tx_data(le_data),
      .tx_valid(le_valid), .tx_ready(tx_ready), .busy(le_busy), .done(le_done));

   bram_dump_streamer #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1), .BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .abort(abort), .debug_addr(be_addr), .debug_data(be_rd), .tx_data(be_data),
      .tx_valid(be_valid), .tx_ready(tx_ready), .busy(be_busy), .done(be_done));

   // Monitor on the falling edge: record bytes whose handshake completes at
   // the next rising edge, count done pulses, and watch stalled bytes.
   always @(negedge clk) begin
      if (le_valid && tx_ready) le_q.push_back(le_data);
      if (be_valid && tx_ready) be_q.push_back(be_data);
      if (le_done) le_done_cnt++;
      if (be_done) be_done_cnt++;
      if (le_valid) valid_seen++;
      if (stall_pend && !(le_valid && (le_data === stall_data))) hold_err++;
      stall_pend = le_valid && !tx_ready;
      stall_data = le_data;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rdy_mode) begin
         tx_ready = rdy_pat[rdy_ph[1:0]];
         rdy_ph   = (rdy_ph + 1) % 4;
      end
   endtask

   task automatic clear_mon();
      le_q.delete();
      be_q.delete();
      le_done_cnt = 0;
      be_done_cnt = 0;
      valid_seen  = 0;
      hold_err    = 0;
      stall_pend  = 1'b0;
   endtask

   task automatic pulse_start(input logic [9:0] b, input logic [8:0] c);
      base_addr  = b;
      word_count = c;
      start      = 1'b1;
      step();
      start      = 1'b0;
   endtask

   task automatic wait_done(input int max, output int cycles, output bit ok);
      ok     = 1'b0;
      cycles = 0;
      for (int i = 0; i < max; i++) begin
         step();
         if (le_done) begin
            cycles = i + 1;
            ok     = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
      base_addr = '0; word_count = '0;
      clear_mon();
      step(); step();
      total++; if (le_addr !== 10'h000) begin bad++; $display("FAIL reset_addr: got %0h want 0", le_addr); end
      total++; if (le_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h want 0", le_data); end
      total++; if ({le_valid, le_busy, le_done} !== 3'b000) begin bad++; $display("FAIL reset_ctl: got %b want 000", {le_valid, le_busy, le_done}); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic();
      logic [7:0] exp_le [8] = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      logic [7:0] exp_be [8] = '{8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h05};
      logic [7:0] got;
      int cyc; bit ok;
      mem[0] = 32'h0000000A; mem[1] = 32'h00000005;
      clear_mon();
      pulse_start(10'h000, 9'd2);
      total++; if (le_busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", le_busy); end
      wait_done(40, cyc, ok);
      step(); step();
      total++; if (!ok) begin bad++; $display("FAIL basic_done_seen: got none want pulse"); end
      total++; if (cyc != 14) begin bad++; $display("FAIL basic_latency: got %0d want 14", cyc); end
      total++; if (le_q.size() != 8) begin bad++; $display("FAIL basic_le_count: got %0d want 8", le_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < le_q.size()) ? le_q[i] : 8'hxx;
         total++; if (got !== exp_le[i]) begin bad++; $display("FAIL basic_le_byte%0d: got %0h want %0h", i, got, exp_le[i]); end
         got = (i < be_q.size()) ? be_q[i] : 8'hxx;
         total++; if (got !== exp_be[i]) begin bad++; $display("FAIL basic_be_byte%0d: got %0h want %0h", i, got, exp_be[i]); end
      end
      total++; if (le_done_cnt != 1 || be_done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d/%0d want 1/1", le_done_cnt, be_done_cnt); end
      total++; if (le_busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy: got %b want 0", le_busy); end
   endtask

   task automatic test_stall();
      logic [7:0] exp_le [8] = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      logic [7:0] got;
      int cyc; bit ok;
      clear_mon();
      rdy_ph = 0; rdy_mode = 1'b1;
      pulse_start(10'h000, 9'd2);
      wait_done(80, cyc, ok);
      step(); step();
      rdy_mode = 1'b0; tx_ready = 1'b1;
      total++; if (!ok) begin bad++; $display("FAIL stall_done_seen: got none want pulse"); end
      total++; if (le_q.size() != 8) begin bad++; $display("FAIL stall_count: got %0d want 8", le_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < le_q.size()) ? le_q[i] : 8'hxx;
         total++; if (got !== exp_le[i]) begin bad++; $display("FAIL stall_byte%0d: got %0h want %0h", i, got, exp_le[i]); end
      end
      total++; if (hold_err != 0) begin bad++; $display("FAIL stall_hold: got %0d changes want 0", hold_err); end
      total++; if (le_done_cnt != 1) begin bad++; $display("FAIL stall_done_cnt: got %0d want 1", le_done_cnt); end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_le [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
      logic [7:0] got;
      int cyc; bit ok;
      mem[255] = 32'h11223344; mem[0] = 32'hAABBCCDD;
      clear_mon();
      pulse_start(10'h3FD, 9'd2);
      total++; if (le_addr !== 10'h3FC) begin bad++; $display("FAIL wrap_align: got %0h want 3fc", le_addr); end
      wait_done(40, cyc, ok);
      step(); step();
      total++; if (!ok) begin bad++; $display("FAIL wrap_done_seen: got none want pulse"); end
      for (int i = 0; i < 8; i++) begin
         got = (i < le_q.size()) ? le_q[i] : 8'hxx;
         total++; if (got !== exp_le[i]) begin bad++; $display("FAIL wrap_byte%0d: got %0h want %0h", i, got, exp_le[i]); end
      end
      total++; if (le_q.size() != 8) begin bad++; $display("FAIL wrap_count: got %0d want 8", le_q.size()); end
      base_addr = '0;
   endtask

   task automatic test_zero_count();
      clear_mon();
      pulse_start(10'h000, 9'd0);
      total++; if ({le_busy, le_done} !== 2'b10) begin bad++; $display("FAIL zero_first: got busy,done=%b want 10", {le_busy, le_done}); end
      step();
      total++; if ({le_busy, le_done} !== 2'b01) begin bad++; $display("FAIL zero_second: got busy,done=%b want 01", {le_busy, le_done}); end
      step();
      total++; if (le_done !== 1'b0) begin bad++; $display("FAIL zero_pulse_len: got %b want 0", le_done); end
      total++; if (valid_seen != 0) begin bad++; $display("FAIL zero_valid: got %0d want 0", valid_seen); end
      total++; if (le_done_cnt != 1) begin bad++; $display("FAIL zero_done_cnt: got %0d want 1", le_done_cnt); end
   endtask

   task automatic test_start_ignored();
      logic [7:0] exp_le [8] = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
      logic [7:0] got;
      int cyc; bit ok;
      mem[0] = 32'h0000000A; mem[1] = 32'h00000005;
      clear_mon();
      pulse_start(10'h000, 9'd2);
      step(); step(); step();
      pulse_start(10'h3FC, 9'd5);
      base_addr = '0;
      wait_done(40, cyc, ok);
      total++; if (!ok) begin bad++; $display("FAIL busy_start_done_seen: got none want pulse"); end
      start = 1'b1; word_count = 9'd1;
      step();
      start = 1'b0;
      total++; if ({le_busy, le_done} !== 2'b00) begin bad++; $display("FAIL done_cycle_start: got busy,done=%b want 00", {le_busy, le_done}); end
      step(); step();
      total++; if (le_q.size() != 8) begin bad++; $display("FAIL busy_start_count: got %0d want 8", le_q.size()); end
      for (int i = 0; i < 8; i++) begin
         got = (i < le_q.size()) ? le_q[i] : 8'hxx;
         total++; if (got !== exp_le[i]) begin bad++; $display("FAIL busy_start_byte%0d: got %0h want %0h", i, got, exp_le[i]); end
      end
      total++; if (le_done_cnt != 1) begin bad++; $display("FAIL busy_start_done_cnt: got %0d want 1", le_done_cnt); end
   endtask

   task automatic test_abort();
      logic [7:0] exp_le [4] = '{8'h0A, 8'h00, 8'h00, 8'h00};
      logic [7:0] got;
      bit found;
      clear_mon();
      pulse_start(10'h000, 9'd2);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (le_q.size() >= 3) begin found = 1'b1; break; end
         step();
      end
      total++; if (!found) begin bad++; $display("FAIL abort_reach3: got %0d bytes want 3", le_q.size()); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      total++; if ({le_valid, le_busy} !== 2'b00) begin bad++; $display("FAIL abort_idle: got valid,busy=%b want 00", {le_valid, le_busy}); end
      for (int i = 0; i < 5; i++) step();
      total++; if (le_q.size() != 4) begin bad++; $display("FAIL abort_count: got %0d want 4", le_q.size()); end
      for (int i = 0; i < 4; i++) begin
         got = (i < le_q.size()) ? le_q[i] : 8'hxx;
         total++; if (got !== exp_le[i]) begin bad++; $display("FAIL abort_byte%0d: got %0h want %0h", i, got, exp_le[i]); end
      end
      total++; if (le_done_cnt != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", le_done_cnt); end
   endtask

   task automatic test_reset_mid();
      bit found;
      clear_mon();
      pulse_start(10'h000, 9'd2);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (le_q.size() >= 2) begin found = 1'b1; break; end
         step();
      end
      total++; if (!found || le_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_send: got valid=%b want 1", le_valid); end
      #2;
      rst = 1'b0;
      #1;
      total++; if ({le_valid, le_busy, le_done} !== 3'b000) begin bad++; $display("FAIL rst_async_ctl: got %b want 000", {le_valid, le_busy, le_done}); end
      total++; if (le_addr !== 10'h000 || le_data !== 8'h00) begin bad++; $display("FAIL rst_async_data: got addr=%0h data=%0h want 0/0", le_addr, le_data); end
      step(); step();
      rst = 1'b1;
      for (int i = 0; i < 5; i++) step();
      total++; if (le_done_cnt != 0 || le_busy !== 1'b0) begin bad++; $display("FAIL rst_after: got done_cnt=%0d busy=%b want 0/0", le_done_cnt, le_busy); end
      total++; if (le_q.size() != 2) begin bad++; $display("FAIL rst_count: got %0d want 2", le_q.size()); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_zero_count();
      test_start_ignored();
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bram_dump_streamer.md
Name: bram_dump_streamer

Overview:
- Reader-side counterpart of the BRAM loading path. Walks a window of a bram32 instance through its debug read port (debug_addr/debug_data).
- Serialises each 32-bit word into a byte stream with a valid/ready handshake, intended to feed a UART TX or a bench monitor.
- Sits beside D_MEM (or I_MEM) in the top level. Lets the Zybo design, or a bench, dump memory after a program runs without touching the CPU's own ports.

Parameters:
- ADDR_WIDTH, 10, byte-address width of the bram32 debug port.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- READ_LATENCY, 1, cycles from debug_addr change to valid debug_data (0 = combinational read).
- BIG_ENDIAN, 0, 0 = least-significant byte first; 1 = most-significant byte first.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  byte address of the first word; bits [1:0] ignored (forced word-aligned).
- word_count  in  ADDR_WIDTH-1  number of words to dump; 0 = none; values >256 clamp to 256.
- abort  in  1  cancels an active dump at the next clock edge.
- debug_addr  out  ADDR_WIDTH  address to bram32 debug port.
- debug_data  in  DATA_WIDTH  data from bram32 debug port.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready on a clock edge.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion (not on abort).

Behaviour:
- Reset (rst=0, async): state IDLE; debug_addr=0, tx_data=0, tx_valid=0, busy=0, done=0; all counters cleared.
- IDLE:
  - start=1 with word_count=0: busy=1 for one cycle, then done pulses. No bytes are sent.
  - start=1 with word_count>0: latch {base_addr[9:2],2'b00} and the clamped count, busy=1, go to ISSUE.
- ISSUE: drive debug_addr = current word address. Load the latency counter with READ_LATENCY, go to WAIT. If READ_LATENCY=0, go directly to CAPTURE.
- WAIT: decrement the latency counter; at 0 go to CAPTURE. debug_addr stays stable throughout WAIT.
- CAPTURE: register debug_data into the shift word, byte_idx=0, go to SEND.
  - debug_data is never used unregistered as tx_data.
- SEND:
  - tx_valid=1; tx_data = byte byte_idx (BIG_ENDIAN selects the order).
  - tx_data is held stable while tx_valid && !tx_ready. tx_valid never drops without a handshake, except on abort or reset.
  - On handshake: if byte_idx<3, increment byte_idx. If byte_idx=3 and words remain, add 4 to the address (mod 2^ADDR_WIDTH, so 0x3FC wraps to 0x000), decrement the remaining count, go to ISSUE.
  - Last byte of the last word: go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, tx_valid=0; return to IDLE.
  - A start in that same cycle is ignored.
  - busy and done are never high together except in the word_count=0 case, where busy falls as done rises.
- Abort:
  - In any non-IDLE state, go to IDLE next edge; tx_valid=0, busy=0, no done pulse.
  - A byte whose handshake coincides with abort counts as transferred.
  - Abort in IDLE has no effect.
- start while busy is ignored; no queuing.
- Throughput: one byte per cycle while tx_ready=1. Per-word overhead is 2+READ_LATENCY bubble cycles (ISSUE, WAIT×latency, CAPTURE).
- Mid-stream reset returns to IDLE immediately regardless of handshake state.

Decomposition:
- Shared constants go in rv32i_params.vh: DATA_WIDTH, the BRAM depth, and new DUMP_ST_IDLE/ISSUE/WAIT/CAPTURE/SEND/DONE state encodings (3-bit).
- One natural sub-module: word_serializer. It holds the captured word and byte_idx, and drives tx_data/tx_valid with the hold-until-ready rule.
- The address/count/latency FSM stays in the top.

Test Plan:
- Preload D_MEM with 0x0000000A at 0x000 and 0x00000005 at 0x004; base=0, count=2, tx_ready=1 → bytes 0A,00,00,00,05,00,00,00 in that order, then one done pulse.
- Same stimulus with BIG_ENDIAN=1 → 00,00,00,0A,00,00,00,05.
- Drive tx_ready as 1,0,0,1 repeating → tx_data constant while stalled, no byte lost or duplicated, 8 bytes total.
- base=0x3FC, count=2, with 0x11223344 at 0x3FC and 0xAABBCCDD at 0x000 → 44,33,22,11,DD,CC,BB,AA (address wrap).
- count=0 → no tx_valid, done one cycle after start. A start pulsed during an active dump → ignored, byte count unchanged.
- Assert abort after the 3rd byte, then assert rst=0 mid-SEND on a second run → outputs idle, no done pulse, busy=0 within one edge (async for rst).
